// File: rtl/alu_exec_ctrl.sv
// Fetch/read/execute/writeback controller around a combinational 8-bit ALU.
// Holds an 8-entry register file, drives the ALU for one EXEC cycle and writes back the result.
module alu_exec_ctrl #(
  parameter int unsigned DATA = 8,
  parameter int unsigned CMD  = 4,
  parameter int unsigned SH   = 3,
  parameter int unsigned NOPS = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [15:0]     instr,
  input  logic [DATA-1:0] in_port,
  input  logic            ld_en,
  input  logic [SH-1:0]   ld_addr,
  input  logic [DATA-1:0] ld_data,
  input  logic [SH-1:0]   dbg_addr,
  output logic [DATA-1:0] dbg_data,
  output logic [CMD-1:0]  alu_fs,
  output logic [DATA-1:0] alu_a,
  output logic [DATA-1:0] alu_b,
  output logic [DATA-1:0] alu_inp,
  output logic [SH-1:0]   alu_shift,
  input  logic [DATA-1:0] alu_out,
  input  logic [4:0]      alu_flags,
  output logic [4:0]      status,
  output logic            done,
  output logic            illegal
);

  localparam int unsigned NREG = 1 << SH;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

  state_t          state_q, state_d;
  logic [15:0]     ir_q;
  logic [DATA-1:0] regs_q [NREG];
  logic [CMD-1:0]  alu_fs_q;
  logic [DATA-1:0] alu_a_q, alu_b_q, alu_inp_q;
  logic [SH-1:0]   alu_shift_q;
  logic [DATA-1:0] res_q;
  logic [4:0]      flg_q;
  logic [4:0]      status_q;

  logic [CMD-1:0]  ir_fs;
  logic [SH-1:0]   ir_rd, ir_ra, ir_rb, ir_sh;
  logic            legal;

  assign ir_fs = ir_q[15:12];
  assign ir_rd = ir_q[11:9];
  assign ir_ra = ir_q[8:6];
  assign ir_rb = ir_q[5:3];
  assign ir_sh = ir_q[2:0];
  assign legal = 32'(ir_fs) < NOPS;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (instr_valid) state_d = S_READ;
      S_READ:  state_d = S_EXEC;
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake and pulses are masked while reset is held so nothing leaks out mid-reset.
  assign instr_ready = rst_n && (state_q == S_IDLE);
  assign done        = rst_n && (state_q == S_WB) && legal;
  assign illegal     = rst_n && (state_q == S_WB) && !legal;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ir_q        <= '0;
      alu_fs_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_inp_q   <= '0;
      alu_shift_q <= '0;
      res_q       <= '0;
      flg_q       <= '0;
      status_q    <= '0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (instr_valid && instr_ready) ir_q <= instr;
      // READ -> EXEC: operands land directly in the ALU drive registers and hold afterwards.
      if (state_q == S_READ) begin
        alu_fs_q    <= ir_fs;
        alu_a_q     <= regs_q[ir_ra];
        alu_b_q     <= regs_q[ir_rb];
        alu_inp_q   <= in_port;
        alu_shift_q <= ir_sh;
      end
      // EXEC -> WB: capture ALU result and flags.
      if (state_q == S_EXEC) begin
        res_q <= alu_out;
        flg_q <= alu_flags;
      end
      if (ld_en) regs_q[ld_addr] <= ld_data;
      // WB -> IDLE: placed after the preload so writeback wins on an address clash.
      if (state_q == S_WB && legal) begin
        regs_q[ir_rd] <= res_q;
        status_q      <= flg_q;
      end
    end
  end

  assign alu_fs    = alu_fs_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_inp   = alu_inp_q;
  assign alu_shift = alu_shift_q;
  assign status    = status_q;
  assign dbg_data  = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl with an XOR stub standing in for the ALU.
module tb_alu_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [7:0]  in_port;
  logic        ld_en;
  logic [2:0]  ld_addr;
  logic [7:0]  ld_data;
  logic [2:0]  dbg_addr;
  logic [7:0]  dbg_data;
  logic [3:0]  alu_fs;
  logic [7:0]  alu_a, alu_b, alu_inp;
  logic [2:0]  alu_shift;
  logic [7:0]  alu_out;
  logic [4:0]  alu_flags;
  logic [4:0]  status;
  logic        done, illegal;
  logic [4:0]  flags_stub;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign alu_out   = alu_a ^ alu_b;
  assign alu_flags = flags_stub;

  alu_exec_ctrl dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .in_port(in_port), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .alu_fs(alu_fs), .alu_a(alu_a), .alu_b(alu_b),
    .alu_inp(alu_inp), .alu_shift(alu_shift), .alu_out(alu_out), .alu_flags(alu_flags),
    .status(status), .done(done), .illegal(illegal)
  );

  typedef struct packed {
    logic [3:0] fs;
    logic [2:0] rd, ra, rb, sh;
    logic [7:0] va, vb, inp;
    logic [4:0] flags;
    logic [7:0] exp_rd;
    logic [4:0] exp_status;
    logic       exp_done;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_reg(input logic [2:0] a, output logic [7:0] d);
    dbg_addr = a;
    #1;
    d = dbg_data;
  endtask

  task automatic preload(input logic [2:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    step();
    ld_en = 1'b0;
  endtask

  // Issues one instruction from IDLE and walks it through READ/EXEC/WB back to IDLE.
  task automatic run_instr(input logic [15:0] ins, input logic [7:0] ea, input logic [7:0] eb,
                           input logic [7:0] einp, input logic legal);
    chk("idle ready", 32'(instr_ready), 32'd1);
    instr_valid = 1'b1; instr = ins;
    step();
    instr_valid = 1'b0;
    chk("read ready", 32'(instr_ready), 32'd0);
    chk("read done", 32'(done), 32'd0);
    step();
    chk("exec fs", 32'(alu_fs), 32'(ins[15:12]));
    chk("exec a", 32'(alu_a), 32'(ea));
    chk("exec b", 32'(alu_b), 32'(eb));
    chk("exec inp", 32'(alu_inp), 32'(einp));
    chk("exec shift", 32'(alu_shift), 32'(ins[2:0]));
    chk("exec done", 32'(done), 32'd0);
    step();
    chk("wb done", 32'(done), 32'(legal));
    chk("wb illegal", 32'(illegal), 32'(!legal));
    chk("wb ready", 32'(instr_ready), 32'd0);
    step();
    chk("back idle ready", 32'(instr_ready), 32'd1);
    chk("idle done", 32'(done), 32'd0);
  endtask

  initial begin
    logic [7:0] d;
    vecs[0] = '{4'd3,  3'd3, 3'd1, 3'd2, 3'd5, 8'h7A, 8'h52, 8'h00, 5'b10001, 8'h28, 5'b10001, 1'b1};
    vecs[1] = '{4'd12, 3'd4, 3'd5, 3'd6, 3'd0, 8'h11, 8'h22, 8'h00, 5'b01110, 8'hEE, 5'b10001, 1'b0};
    vecs[2] = '{4'd0,  3'd2, 3'd2, 3'd2, 3'd7, 8'h3C, 8'h3C, 8'hA5, 5'b00000, 8'h00, 5'b00000, 1'b1};
    vecs[3] = '{4'd9,  3'd0, 3'd7, 3'd0, 3'd1, 8'hFF, 8'h0F, 8'h5A, 5'b11111, 8'hF0, 5'b11111, 1'b1};
    vecs[4] = '{4'd10, 3'd5, 3'd6, 3'd7, 3'd2, 8'h01, 8'h02, 8'h00, 5'b10101, 8'hEE, 5'b11111, 1'b0};
    vecs[5] = '{4'd15, 3'd7, 3'd0, 3'd1, 3'd3, 8'h80, 8'h7F, 8'h00, 5'b00000, 8'hEE, 5'b11111, 1'b0};
    vecs[6] = '{4'd5,  3'd6, 3'd4, 3'd3, 3'd6, 8'h80, 8'h7F, 8'h3C, 5'b01010, 8'hFF, 5'b01010, 1'b1};

    rst_n = 1'b0; instr_valid = 1'b0; instr = '0; in_port = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0; flags_stub = 5'b10001;

    // Reset held two cycles.
    step(); step();
    chk("rst ready", 32'(instr_ready), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst illegal", 32'(illegal), 32'd0);
    chk("rst status", 32'(status), 32'd0);
    chk("rst alu_a", 32'(alu_a), 32'd0);
    chk("rst alu_fs", 32'(alu_fs), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("post-rst ready", 32'(instr_ready), 32'd1);
    for (int a = 0; a < 8; a++) begin
      rd_reg(3'(a), d);
      chk("rst reg", 32'(d), 32'd0);
    end

    // Table-driven instructions.
    for (int i = 0; i < 7; i++) begin
      flags_stub = vecs[i].flags;
      in_port    = vecs[i].inp;
      preload(vecs[i].rd, 8'hEE);
      preload(vecs[i].ra, vecs[i].va);
      preload(vecs[i].rb, vecs[i].vb);
      run_instr({vecs[i].fs, vecs[i].rd, vecs[i].ra, vecs[i].rb, vecs[i].sh},
                vecs[i].va, vecs[i].vb, vecs[i].inp, vecs[i].exp_done);
      rd_reg(vecs[i].rd, d);
      chk("vec rd", 32'(d), 32'(vecs[i].exp_rd));
      chk("vec status", 32'(status), 32'(vecs[i].exp_status));
    end

    // Illegal FS must leave r1 and status alone.
    preload(3'd1, 8'h7A); preload(3'd2, 8'h52);
    flags_stub = 5'b01110;
    run_instr({4'd12, 3'd1, 3'd1, 3'd2, 3'd0}, 8'h7A, 8'h52, 8'h3C, 1'b0);
    rd_reg(3'd1, d);
    chk("illegal r1", 32'(d), 32'h7A);
    chk("illegal status", 32'(status), 32'(5'b01010));
    flags_stub = 5'b10001;

    // Back-to-back offers: only IDLE cycles accept; rd tags which offer got in.
    for (int a = 0; a < 8; a++) if (a != 1 && a != 2) preload(3'(a), 8'h00);
    for (int k = 0; k < 8; k++) begin
      instr_valid = 1'b1;
      instr = {4'd3, 3'(k), 3'd1, 3'd2, 3'd0};
      chk("b2b ready", 32'(instr_ready), 32'((k % 4) == 0));
      chk("b2b done", 32'(done), 32'((k % 4) == 3));
      step();
    end
    instr_valid = 1'b0;
    chk("b2b end ready", 32'(instr_ready), 32'd1);
    rd_reg(3'd0, d); chk("b2b r0", 32'(d), 32'h28);
    rd_reg(3'd4, d); chk("b2b r4", 32'(d), 32'h28);
    rd_reg(3'd3, d); chk("b2b r3", 32'(d), 32'h00);
    rd_reg(3'd5, d); chk("b2b r5", 32'(d), 32'h00);
    rd_reg(3'd1, d); chk("b2b r1", 32'(d), 32'h7A);

    // Preload to r3 in the same WB cycle that writes r3: writeback wins.
    instr_valid = 1'b1; instr = {4'd3, 3'd3, 3'd1, 3'd2, 3'd5};
    step();
    instr_valid = 1'b0;
    step(); step();
    chk("clash wb done", 32'(done), 32'd1);
    ld_en = 1'b1; ld_addr = 3'd3; ld_data = 8'h55;
    step();
    ld_en = 1'b0;
    rd_reg(3'd3, d);
    chk("clash r3", 32'(d), 32'h28);

    // Preload to ra during READ: this instruction still sees the old value.
    instr_valid = 1'b1; instr = {4'd3, 3'd6, 3'd1, 3'd2, 3'd0};
    step();
    instr_valid = 1'b0;
    ld_en = 1'b1; ld_addr = 3'd1; ld_data = 8'h00;
    step();
    ld_en = 1'b0;
    chk("read-ld alu_a", 32'(alu_a), 32'h7A);
    step(); step();
    rd_reg(3'd6, d); chk("read-ld r6", 32'(d), 32'h28);
    rd_reg(3'd1, d); chk("read-ld r1", 32'(d), 32'h00);

    // Reset during EXEC aborts: no done, no writeback, all state cleared.
    preload(3'd1, 8'h7A);
    instr_valid = 1'b1; instr = {4'd3, 3'd7, 3'd1, 3'd2, 3'd0};
    step();
    instr_valid = 1'b0;
    step();
    chk("abort exec a", 32'(alu_a), 32'h7A);
    rst_n = 1'b0;
    #1;
    chk("abort rst ready", 32'(instr_ready), 32'd0);
    step();
    chk("abort rst done", 32'(done), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("abort ready", 32'(instr_ready), 32'd1);
    chk("abort done", 32'(done), 32'd0);
    chk("abort illegal", 32'(illegal), 32'd0);
    chk("abort status", 32'(status), 32'd0);
    chk("abort alu_a", 32'(alu_a), 32'd0);
    for (int a = 0; a < 8; a++) begin
      rd_reg(3'(a), d);
      chk("abort reg", 32'(d), 32'd0);
    end
    step();
    chk("abort no late done", 32'(done), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
